demux_router: RTL and testbench

Registered 1-to-4 result demultiplexer with valid/ready handshakes. It is the distribution counterpart of the ALU result select stage. It takes a single 8-bit result stream plus a 2-bit channel select and steers each accepted byte into one of four single-entry output buffers, which downstream consumers drain independently. It sits between the ALU result path and the four consumer blocks: display, register file, LED latch and debug tap.

---
 rtl/demux_router.sv | 75 +++++++
 tb/tb_demux_router.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_router.sv
// Registered 1-to-4 result demultiplexer with single-entry output buffers.
// Optional broadcast to all channels when DEMUX_BROADCAST_EN is defined.
module demux_router (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_data_i,
    input  logic [1:0] in_sel_i,
`ifdef DEMUX_BROADCAST_EN
    input  logic       bcast_i,
`endif
    output logic [3:0] out_valid_o,
    input  logic [3:0] out_ready_i,
    output logic [7:0] out_data0_o,
    output logic [7:0] out_data1_o,
    output logic [7:0] out_data2_o,
    output logic [7:0] out_data3_o,
    output logic       busy_o
);

    logic [3:0] r_vld;
    logic [7:0] r_data [4];

    logic [3:0] w_free;
    logic [3:0] w_onehot;
    logic [3:0] w_load;
    logic       w_ready;
    logic       w_acc;

    // A full buffer whose consumer is taking this cycle can be refilled.
    assign w_free = ~r_vld | out_ready_i;

    always_comb begin
        w_onehot = 4'b0000;
        w_onehot[in_sel_i] = 1'b1;
    end

`ifdef DEMUX_BROADCAST_EN
    assign w_ready = bcast_i ? (&w_free) : w_free[in_sel_i];
    assign w_acc   = in_valid_i & w_ready;
    assign w_load  = bcast_i ? {4{w_acc}} : (w_onehot & {4{w_acc}});
`else
    assign w_ready = w_free[in_sel_i];
    assign w_acc   = in_valid_i & w_ready;
    assign w_load  = w_onehot & {4{w_acc}};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                r_data[n] <= 8'h00;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_load[n]) begin
                    r_vld[n]  <= 1'b1;
                    r_data[n] <= in_data_i;
                end else if (out_ready_i[n]) begin
                    r_vld[n] <= 1'b0;
                end
            end
        end
    end

    assign in_ready_o  = w_ready;
    assign out_valid_o = r_vld;
    assign out_data0_o = r_data[0];
    assign out_data1_o = r_data[1];
    assign out_data2_o = r_data[2];
    assign out_data3_o = r_data[3];
    assign busy_o      = |r_vld;

endmodule

// File: tb/tb_demux_router.sv
// Randomized and directed bench for demux_router against a queue model.
// Define DEMUX_BROADCAST_EN to also exercise the broadcast path.
module tb_demux_router;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [7:0] in_data_i = 8'h00;
    logic [1:0] in_sel_i = 2'b00;
    logic [3:0] out_valid_o;
    logic [3:0] out_ready_i = 4'b0000;
    logic [7:0] out_data0_o, out_data1_o, out_data2_o, out_data3_o;
    logic       busy_o;
`ifdef DEMUX_BROADCAST_EN
    logic       bcast_i = 1'b0;
`endif

    demux_router dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_sel_i    (in_sel_i),
`ifdef DEMUX_BROADCAST_EN
        .bcast_i     (bcast_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data0_o (out_data0_o),
        .out_data1_o (out_data1_o),
        .out_data2_o (out_data2_o),
        .out_data3_o (out_data3_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] dout [4];
    assign dout[0] = out_data0_o;
    assign dout[1] = out_data1_o;
    assign dout[2] = out_data2_o;
    assign dout[3] = out_data3_o;

    // Model: each channel is a queue of at most one byte; last remembers
    // the most recent byte handed out so the data lines can be predicted.
    logic [7:0] mq [4][$];
    logic [7:0] mlast [4];
    logic       macc = 1'b0;
    logic [7:0] cap [$];

    function automatic logic bc_now();
`ifdef DEMUX_BROADCAST_EN
        return bcast_i;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic mfree(int n);
        return (mq[n].size() == 0) || out_ready_i[n];
    endfunction

    function automatic logic exp_ready();
        if (bc_now())
            return mfree(0) && mfree(1) && mfree(2) && mfree(3);
        return mfree(int'(in_sel_i));
    endfunction

    function automatic logic [7:0] exp_data(int n);
        return (mq[n].size() != 0) ? mq[n][0] : mlast[n];
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = (mq[n].size() != 0);
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < 4; n++) begin
                mq[n].delete();
                mlast[n] = 8'h00;
            end
            macc = 1'b0;
        end else begin
            logic acc;
            logic bc;
            int   sel;
            acc = in_valid_i && exp_ready();
            bc  = bc_now();
            sel = int'(in_sel_i);
            if (out_valid_o[1] && out_ready_i[1]) cap.push_back(out_data1_o);
            for (int n = 0; n < 4; n++) begin
                if (out_ready_i[n] && mq[n].size() != 0)
                    mlast[n] = mq[n].pop_front();
                if (acc && (bc || sel == n)) begin
                    mq[n].push_back(in_data_i);
                    mlast[n] = in_data_i;
                end
            end
            macc = acc;
        end
    end

    always @(negedge clk_i) begin
        chk("out_valid", 32'(out_valid_o), 32'(exp_valid()));
        chk("busy", 32'(busy_o), 32'(|exp_valid()));
        chk("in_ready", 32'(in_ready_o), 32'(exp_ready()));
        for (int n = 0; n < 4; n++)
            chk($sformatf("data%0d", n), 32'(dout[n]), 32'(exp_data(n)));
    end

    task automatic drive(logic v, logic [7:0] d, logic [1:0] s, logic [3:0] r);
        @(negedge clk_i);
        #1;
        in_valid_i  = v;
        in_data_i   = d;
        in_sel_i    = s;
        out_ready_i = r;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            in_valid_i  = 1'($urandom);
            in_data_i   = 8'($urandom);
            in_sel_i    = 2'($urandom);
            out_ready_i = 4'($urandom);
        end
        #1;
        chk("rst_valid", 32'(out_valid_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_data3", 32'(out_data3_o), 32'h0);
        in_valid_i = 1'b0;
        rst_ni = 1'b1;
        #1;
        chk("rel_ready", 32'(in_ready_o), 32'h1);

        drive(1'b1, 8'hA5, 2'd0, 4'b0000);
        drive(1'b1, 8'h3C, 2'd1, 4'b0000);
        drive(1'b1, 8'hF0, 2'd2, 4'b0000);
        drive(1'b1, 8'h0F, 2'd3, 4'b0000);
        drive(1'b1, 8'h99, 2'd2, 4'b0000);
        chk("route_full_ready", 32'(in_ready_o), 32'h0);
        chk("route_valid", 32'(out_valid_o), 32'hF);
        chk("route_d0", 32'(out_data0_o), 32'hA5);
        chk("route_d1", 32'(out_data1_o), 32'h3C);
        chk("route_d2", 32'(out_data2_o), 32'hF0);
        chk("route_d3", 32'(out_data3_o), 32'h0F);

        drive(1'b0, 8'h00, 2'd0, 4'b1111);
        drive(1'b1, 8'h11, 2'd2, 4'b0000);
        drive(1'b1, 8'h22, 2'd2, 4'b0100);
        chk("pass_ready", 32'(in_ready_o), 32'h1);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        chk("pass_valid2", 32'(out_valid_o[2]), 32'h1);
        chk("pass_d2", 32'(out_data2_o), 32'h22);

        drive(1'b0, 8'h00, 2'd0, 4'b1111);
        cap.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 2'd1, 4'b0010);
            chk("stream_ready", 32'(in_ready_o), 32'h1);
        end
        drive(1'b0, 8'h00, 2'd1, 4'b0010);
        drive(1'b0, 8'h00, 2'd1, 4'b0010);
        chk("stream_count", 32'(cap.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < cap.size()) chk("stream_order", 32'(cap[i]), 32'(i));
        end

        drive(1'b1, 8'hAA, 2'd0, 4'b0000);
        drive(1'b1, 8'hBB, 2'd3, 4'b0000);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        chk("mid_pre_valid", 32'(out_valid_o), 32'h9);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid_o), 32'h0);
        chk("mid_rst_d0", 32'(out_data0_o), 32'h0);
        #1;
        rst_ni = 1'b1;
        drive(1'b1, 8'hCC, 2'd0, 4'b0000);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        chk("post_rst_valid", 32'(out_valid_o), 32'h1);
        chk("post_rst_d0", 32'(out_data0_o), 32'hCC);

`ifdef DEMUX_BROADCAST_EN
        drive(1'b0, 8'h00, 2'd0, 4'b1111);
        drive(1'b1, 8'h55, 2'd1, 4'b0000);
        bcast_i = 1'b1;
        drive(1'b1, 8'h77, 2'd0, 4'b0000);
        chk("bc_blocked", 32'(in_ready_o), 32'h0);
        drive(1'b1, 8'h77, 2'd0, 4'b0010);
        chk("bc_ready", 32'(in_ready_o), 32'h1);
        bcast_i = 1'b0;
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        chk("bc_valid", 32'(out_valid_o), 32'hF);
        for (int n = 0; n < 4; n++)
            chk("bc_data", 32'(dout[n]), 32'h77);
`endif

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            #1;
            out_ready_i = 4'($urandom);
            if (!(in_valid_i && !macc)) begin
                in_valid_i = ($urandom_range(0, 3) != 0);
                in_data_i  = 8'($urandom);
                in_sel_i   = 2'($urandom);
`ifdef DEMUX_BROADCAST_EN
                bcast_i    = ($urandom_range(0, 7) == 0);
`endif
            end
        end
        drive(1'b0, 8'h00, 2'd0, 4'b1111);
        drive(1'b0, 8'h00, 2'd0, 4'b0000);
        chk("final_idle", 32'(busy_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
